// File: rtl/data_ram_bank.sv
// Single-port, byte-writable data memory for the core's load/store port.
// Reads and writes both complete with one-cycle latency.
module data_ram_bank #(
    parameter int DEPTH = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic        wr_en_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        data_rvalid_o,
    output logic        write_success_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic          wr_acc;
    logic          rd_acc;
    logic [31:0]   rdata_reg;
    logic          rvalid_reg;
    logic          wsucc_reg;
    logic          unused_addr;

    // Byte offset and bits above the array size are deliberately dropped,
    // so accesses wrap modulo the array size.
    assign word_idx    = addr_i[AW+1:2];
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign wr_acc = ce_i & wr_en_i & ~rst_i;
    assign rd_acc = ce_i & ~wr_en_i & ~rst_i;

    // Array storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_i[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            wsucc_reg  <= 1'b0;
        end else begin
            rvalid_reg <= ce_i;
            wsucc_reg  <= wr_acc;
            if (rd_acc) begin
                rdata_reg <= mem[word_idx];
            end
        end
    end

    assign rdata_o         = rdata_reg;
    assign data_rvalid_o   = rvalid_reg;
    assign write_success_o = wsucc_reg;
endmodule

// File: tb/tb_data_ram_bank.sv
// Directed bench for data_ram_bank: reset, word and byte-lane writes,
// back-to-back reads, address wrap and idle hold.
module tb_data_ram_bank;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        data_rvalid_o;
    logic        write_success_o;

    int checks = 0;
    int errors = 0;

    data_ram_bank #(.DEPTH(4096)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ce_i           (ce_i),
        .wr_en_i        (wr_en_i),
        .sel_i          (sel_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .rdata_o        (rdata_o),
        .data_rvalid_o  (data_rvalid_o),
        .write_success_o(write_success_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one request, let it be taken at the next edge, return 1ns later.
    task automatic req(input logic ce, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd);
        ce_i = ce; wr_en_i = we; sel_i = sel; addr_i = addr; wdata_i = wd;
        @(posedge clk_i);
        #1;
        $display("REQ ce=%0b we=%0b sel=%h addr=%h wdata=%h -> rdata=%h rvalid=%0b wsucc=%0b",
                 ce, we, sel, addr, wd, rdata_o, data_rvalid_o, write_success_o);
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({rdata_o, data_rvalid_o, write_success_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_initial got %h/%b/%b want 0/0/0", rdata_o, data_rvalid_o, write_success_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        req(1, 1, 4'hF, 32'h100, 32'h1234_5678);
        req(1, 0, 4'h0, 32'h100, 32'h0);
        checks++;
        if (rdata_o !== 32'h1234_5678 || data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_preread got %h/%b want 12345678/1", rdata_o, data_rvalid_o);
        end
        // Another read is in flight; reset lands 2ns after the edge.
        ce_i = 1'b1; wr_en_i = 1'b0; addr_i = 32'h100;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({rdata_o, data_rvalid_o, write_success_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_immediate got %h/%b/%b want 0/0/0", rdata_o, data_rvalid_o, write_success_o);
        end
        ce_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        req(0, 0, 4'h0, 32'h0, 32'h0);
        req(0, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if ({rdata_o, data_rvalid_o, write_success_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_idle got %h/%b/%b want 0/0/0", rdata_o, data_rvalid_o, write_success_o);
        end
        // Reset must not clear the array.
        req(1, 0, 4'h0, 32'h100, 32'h0);
        checks++;
        if (rdata_o !== 32'h1234_5678 || data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_keeps_mem got %h/%b want 12345678/1", rdata_o, data_rvalid_o);
        end
    endtask

    task automatic test_word_rw;
        req(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (data_rvalid_o !== 1'b1 || write_success_o !== 1'b1 || rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL word_write_pulse got %h/%b/%b want 12345678/1/1", rdata_o, data_rvalid_o, write_success_o);
        end
        req(1, 0, 4'h0, 32'h10, 32'h0);
        checks++;
        if (rdata_o !== 32'hDEAD_BEEF || data_rvalid_o !== 1'b1 || write_success_o !== 1'b0) begin
            errors++;
            $display("FAIL word_read got %h/%b/%b want deadbeef/1/0", rdata_o, data_rvalid_o, write_success_o);
        end
    endtask

    task automatic test_byte_lanes;
        req(1, 1, 4'hF, 32'h0, 32'h1122_3344);
        req(1, 1, 4'b0101, 32'h0, 32'hAABB_CCDD);
        req(1, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rdata_o !== 32'h11BB_33DD || data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL byte_sel0101 got %h/%b want 11bb33dd/1", rdata_o, data_rvalid_o);
        end
        req(1, 1, 4'b0000, 32'h0, 32'hFFFF_FFFF);
        checks++;
        if (data_rvalid_o !== 1'b1 || write_success_o !== 1'b1 || rdata_o !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL byte_sel0_pulse got %h/%b/%b want 11bb33dd/1/1", rdata_o, data_rvalid_o, write_success_o);
        end
        req(1, 0, 4'hF, 32'h0, 32'h0);
        checks++;
        if (rdata_o !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL byte_sel0_data got %h want 11bb33dd", rdata_o);
        end
        // Upper lanes alone, to catch lane-index faults.
        req(1, 1, 4'b1010, 32'h0, 32'h5566_7788);
        req(1, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rdata_o !== 32'h55BB_77DD) begin
            errors++;
            $display("FAIL byte_sel1010 got %h want 55bb77dd", rdata_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        req(1, 1, 4'hF, 32'h0, 32'd1);
        req(1, 1, 4'hF, 32'h4, 32'd2);
        req(1, 1, 4'hF, 32'h8, 32'd3);
        for (int i = 0; i < 3; i++) begin
            exp = 32'(i + 1);
            req(1, 0, 4'h0, 32'(4 * i), 32'h0);
            checks++;
            if (rdata_o !== exp || data_rvalid_o !== 1'b1 || write_success_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_read%0d got %h/%b/%b want %h/1/0", i, rdata_o, data_rvalid_o, write_success_o, exp);
            end
        end
        req(0, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (data_rvalid_o !== 1'b0 || rdata_o !== 32'd3) begin
            errors++;
            $display("FAIL b2b_idle got %h/%b want 3/0", rdata_o, data_rvalid_o);
        end
    endtask

    task automatic test_wrap;
        req(1, 1, 4'hF, 32'h0000_4000, 32'h5A5A_5A5A);
        req(1, 0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rdata_o !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL wrap_4000 got %h want 5a5a5a5a", rdata_o);
        end
        req(1, 1, 4'hF, 32'h4, 32'h0BAD_F00D);
        req(1, 0, 4'h0, 32'h3, 32'h0);
        checks++;
        if (rdata_o !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL align_3 got %h want 5a5a5a5a", rdata_o);
        end
        req(1, 0, 4'h0, 32'hFFFF_C006, 32'h0);
        checks++;
        if (rdata_o !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wrap_high got %h want 0badf00d", rdata_o);
        end
    endtask

    task automatic test_idle_hold;
        req(1, 1, 4'hF, 32'h20, 32'h1234_5678);
        req(1, 0, 4'h0, 32'h20, 32'h0);
        checks++;
        if (rdata_o !== 32'h1234_5678 || data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_read got %h/%b want 12345678/1", rdata_o, data_rvalid_o);
        end
        for (int i = 0; i < 5; i++) begin
            req(0, 1, 4'hF, 32'h20, 32'hFFFF_FFFF);
            checks++;
            if (rdata_o !== 32'h1234_5678 || data_rvalid_o !== 1'b0 || write_success_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold%0d got %h/%b/%b want 12345678/0/0", i, rdata_o, data_rvalid_o, write_success_o);
            end
        end
        // ce_i=0 with wr_en_i=1 must not have written.
        req(1, 0, 4'h0, 32'h20, 32'h0);
        checks++;
        if (rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL idle_no_write got %h want 12345678", rdata_o);
        end
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_byte_lanes;
        test_back_to_back;
        test_wrap;
        test_idle_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
